control_sequencer: RTL and testbench
====================================

# control_sequencer

Multi-cycle control FSM for the RV32 core. It fetches each instruction over an instruction-memory handshake, latches it into the instruction register that feeds the decoder, and steps the datapath through decode, execute, memory and writeback. It owns the PC and issues the register-file write strobe, immediate-mux select and data-memory handshake. It is the only block that sequences the decoder/ALU/register-file datapath.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address, equals pc
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- ir  out  32  instruction register, drives decoder
- opcode  in  7  opcode from decoder (ir[6:0])
- branch_taken  in  1  branch condition from ALU, sampled in EXECUTE
- target  in  32  branch/JAL target from the address adder
- dmem_req  out  1  data-memory store request
- dmem_ready  in  1  store accepted
- rf_we  out  1  register-file write enable
- imm_sel  out  1  ALU operand B = immediate
- pc  out  32  current PC
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  32  retired-instruction counter
- halted  out  1  sticky illegal-opcode / misaligned-target flag

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- Legal opcodes: 0110011 (reg-reg), 0010011 (imm), 0110111 (LUI), 0100011 (store), 1100011 (branch), 1101111 (JAL).
- FETCH: imem_req=1, imem_addr=pc. Hold both stable until imem_ready. On ready: ir<=imem_rdata, go to DECODE.
- DECODE: one cycle. Legal opcode -> EXECUTE. Any other opcode -> HALT.
- EXECUTE: one cycle. imem_req=0. imm_sel=1 for imm, LUI, store, JAL.
  - reg-reg/imm/LUI/JAL -> WRITEBACK.
  - store -> MEMORY.
  - branch: the next PC is target if branch_taken, else pc+4. Assert retire and go to FETCH.
- MEMORY: dmem_req=1. Hold it until dmem_ready. On ready: pc<=pc+4, retire, go to FETCH.
- WRITEBACK: rf_we=1 for exactly one cycle. pc<=target for JAL, else pc+4. Assert retire and go to FETCH.
- HALT: all requests and strobes are 0 and halted=1. Only reset leaves this state.
- Misaligned target: a taken branch or JAL with target[1:0]!=0 goes to HALT. PC and instret are not updated.
- Arithmetic:
  - pc+4 wraps modulo 2^32.
  - instret increments by 1 on each retire and wraps from 32'hFFFF_FFFF to 0.
- Output decoding: imem_req, dmem_req, rf_we, imm_sel and halted decode from state and ir only (Moore style). retire is combinational with the qualifying transition.

## Timing
- Reset (async assert, sync release):
  - state=FETCH, pc=RESET_PC, ir=32'h0000_0013 (NOP), instret=0, halted=0.
  - All request and strobe outputs are 0 while rst=1.
- First imem_req occurs in the first cycle after rst deasserts.
- Cycle counts, with zero-wait memory (ready in the same cycle as the request):
  - reg-reg/imm/LUI/JAL: 4 cycles.
  - branch: 3 cycles.
  - store: 4 cycles.
  - Each wait cycle on imem_ready or dmem_ready adds 1.
- Handshake rules:
  - A request never drops without ready. Address and request stay stable while waiting.
  - ready while the matching req=0 is ignored.
- Reset mid-handshake: the request drops immediately (async). The pending transfer is abandoned and no retire occurs.
- pc updates on the same edge that leaves EXECUTE (branch), MEMORY or WRITEBACK.
- retire is high in the cycle before that edge.

## Test plan
- Reset: hold rst, then release with RESET_PC=32'h100 -> pc=0x100, ir=0x13, instret=0. imem_req=1 with imem_addr=0x100 on the next cycle.
- ADDI x1,x0,5 (0x00500093), zero-wait fetch -> sequence FETCH, DECODE, EXECUTE, WRITEBACK. imm_sel=1 in EXECUTE, one rf_we pulse, pc=0x104, instret=1, 4 cycles total.
- Fetch with 3 wait cycles -> imem_req and imem_addr stay constant for 4 cycles. ir loads only on the ready cycle.
- BEQ with branch_taken=1, target=0x200 -> pc=0x200 after 3 cycles, no rf_we. Repeat with branch_taken=0 -> pc=pc+4. Repeat with target=0x202 -> halted=1, pc unchanged.
- Store with dmem_ready delayed 2 cycles -> dmem_req high for 3 cycles, no rf_we, pc+=4, instret+1.
- Opcode 0000011 -> halted=1 with all outputs 0 permanently. An async rst pulse mid-FETCH drops imem_req within the same cycle and restores reset values.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Instruction- and data-memory handshake bundle for the control sequencer.
// The sequencer is the master (drives requests and the fetch address);
// the memory side is the slave (returns ready and fetched data).
interface control_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    output dmem_req,
    input  imem_ready,
    input  imem_rdata,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  dmem_req,
    output imem_ready,
    output imem_rdata,
    output dmem_ready
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM for the RV32 core: fetch, decode, execute, memory,
// writeback. Owns the PC, the instruction register and the retire counter.
// Request/strobe outputs are Moore decodes of state and ir, forced low while
// reset is asserted so nothing reaches the memories during reset.
module control_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  control_sequencer_if.master        bus,
  output logic [31:0]                ir,
  input  logic [6:0]                 opcode,
  input  logic                       branch_taken,
  input  logic [31:0]                target,
  output logic                       rf_we,
  output logic                       imm_sel,
  output logic [31:0]                pc,
  output logic                       retire,
  output logic [31:0]                instret,
  output logic                       halted
);

  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    HALT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic        ir_ld;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_IMM) || (op == OP_LUI) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

  function automatic logic uses_imm(input logic [6:0] op);
    return (op == OP_IMM) || (op == OP_LUI) || (op == OP_STORE) || (op == OP_JAL);
  endfunction

  // Sequential successor PC; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_inc(input logic [31:0] p);
    return p + 32'd4;
  endfunction

  function automatic logic misaligned(input logic [31:0] t);
    return t[1:0] != 2'b00;
  endfunction

  // State, PC, instruction register and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= NOP;
      instret <= 32'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ir_ld) ir <= bus.imem_rdata;
      if (retire) instret <= instret + 32'd1;
    end
  end

  // Next-state, next-PC and the retire pulse for the qualifying transition.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_ld     = 1'b0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        if (bus.imem_ready) begin
          ir_ld     = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        state_nxt = is_legal(opcode) ? EXECUTE : HALT;
      end
      EXECUTE: begin
        if (opcode == OP_STORE) begin
          state_nxt = MEMORY;
        end else if (opcode == OP_BRANCH) begin
          if (branch_taken && misaligned(target)) begin
            state_nxt = HALT;
          end else begin
            pc_nxt    = branch_taken ? target : pc_inc(pc);
            retire    = 1'b1;
            state_nxt = FETCH;
          end
        end else if ((opcode == OP_JAL) && misaligned(target)) begin
          state_nxt = HALT;
        end else begin
          state_nxt = WRITEBACK;
        end
      end
      MEMORY: begin
        if (bus.dmem_ready) begin
          pc_nxt    = pc_inc(pc);
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      WRITEBACK: begin
        pc_nxt    = (opcode == OP_JAL) ? target : pc_inc(pc);
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = HALT;
      end
    endcase
  end

  // Moore output decode; requests drop combinationally when reset asserts.
  always_comb begin
    bus.imem_req  = (state == FETCH) && !rst;
    bus.imem_addr = pc;
    bus.dmem_req  = (state == MEMORY) && !rst;
    rf_we         = (state == WRITEBACK) && !rst;
    imm_sel       = (state == EXECUTE) && uses_imm(ir[6:0]) && !rst;
    halted        = (state == HALT) && !rst;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. Each instruction is expanded by a
// behavioural model into a per-cycle schedule of inputs and expected outputs
// (fetch waits, decode, execute, memory waits, writeback), which a single
// runner applies and compares cycle by cycle.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic [31:0] target;
  logic        rf_we;
  logic        imm_sel;
  logic [31:0] pc;
  logic        retire;
  logic [31:0] instret;
  logic        halted;

  control_sequencer_if bus ();

  control_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .ir           (ir),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .target       (target),
    .rf_we        (rf_we),
    .imm_sel      (imm_sel),
    .pc           (pc),
    .retire       (retire),
    .instret      (instret),
    .halted       (halted)
  );

  // Decoder stand-in: opcode field of the instruction register.
  assign opcode = ir[6:0];

  always #5 clk = ~clk;

  typedef struct {
    logic        i_rdy;
    logic [31:0] rdata;
    logic        d_rdy;
    logic        taken;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        dreq;
    logic        we;
    logic        isel;
    logic        ret;
    logic        hlt;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] instret;
  } cyc_t;

  cyc_t q[$];

  int passed = 0;
  int total  = 0;

  logic [31:0] mpc, mir, minstret;
  logic        mhalted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mpc = 32'h100; mir = 32'h13; minstret = 0; mhalted = 0;
  endtask

  task automatic base(output cyc_t r, input logic taken, input logic [31:0] tgt,
                      input logic noise, input logic [31:0] cur_ir);
    r = '{default: '0};
    r.taken = taken; r.tgt = tgt;
    r.i_rdy = noise; r.d_rdy = noise;
    r.pc = mpc; r.instret = minstret; r.ir = cur_ir; r.hlt = mhalted;
  endtask

  // Expand one instruction into its expected cycle schedule.
  task automatic add_instr(input logic [31:0] instr, input int fw, input int dw,
                           input logic taken, input logic [31:0] tgt, input logic noise);
    cyc_t r, r2;
    logic [6:0] op;
    logic legal, isel, mis;
    op    = instr[6:0];
    legal = op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0100011, 7'b1100011, 7'b1101111};
    isel  = op inside {7'b0010011, 7'b0110111, 7'b0100011, 7'b1101111};
    base(r, taken, tgt, noise, instr);
    for (int i = 0; i <= fw; i++) begin
      r2 = r;
      r2.i_rdy = (i == fw);
      r2.rdata = (i == fw) ? instr : 32'hDEAD_BEEF;
      r2.req = 1'b1; r2.addr = mpc; r2.ir = mir;
      q.push_back(r2);
    end
    mir = instr;
    q.push_back(r);
    if (!legal) begin
      mhalted = 1'b1;
      return;
    end
    r2 = r; r2.isel = isel;
    if (op == 7'b1100011) begin
      mis = taken && (tgt[1:0] != 2'b00);
      r2.ret = !mis;
      q.push_back(r2);
      if (mis) mhalted = 1'b1;
      else begin
        mpc = taken ? tgt : mpc + 32'd4;
        minstret = minstret + 1;
      end
      return;
    end
    q.push_back(r2);
    if ((op == 7'b1101111) && (tgt[1:0] != 2'b00)) begin
      mhalted = 1'b1;
      return;
    end
    if (op == 7'b0100011) begin
      for (int i = 0; i <= dw; i++) begin
        r2 = r; r2.dreq = 1'b1; r2.d_rdy = (i == dw); r2.ret = (i == dw);
        q.push_back(r2);
      end
      mpc = mpc + 32'd4;
    end else begin
      r2 = r; r2.we = 1'b1; r2.ret = 1'b1;
      q.push_back(r2);
      mpc = (op == 7'b1101111) ? tgt : mpc + 32'd4;
    end
    minstret = minstret + 1;
  endtask

  task automatic add_idle(input int n, input logic noise);
    cyc_t r;
    base(r, 1'b1, 32'h400, noise, mir);
    for (int i = 0; i < n; i++) q.push_back(r);
  endtask

  // Apply one scheduled cycle (called at posedge+1), compare at negedge.
  task automatic step();
    cyc_t r;
    r = q.pop_front();
    bus.imem_ready = r.i_rdy;
    bus.imem_rdata = r.rdata;
    bus.dmem_ready = r.d_rdy;
    branch_taken   = r.taken;
    target         = r.tgt;
    @(negedge clk);
    chk("imem_req", 32'(bus.imem_req), 32'(r.req));
    if (r.req) chk("imem_addr", bus.imem_addr, r.addr);
    chk("dmem_req", 32'(bus.dmem_req), 32'(r.dreq));
    chk("rf_we",    32'(rf_we),        32'(r.we));
    chk("imm_sel",  32'(imm_sel),      32'(r.isel));
    chk("retire",   32'(retire),       32'(r.ret));
    chk("halted",   32'(halted),       32'(r.hlt));
    chk("pc",       pc,                r.pc);
    chk("ir",       ir,                r.ir);
    chk("instret",  instret,           r.instret);
    @(posedge clk);
    #1;
  endtask

  task automatic run();
    while (q.size() > 0) step();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
    chk({tag, "_dmem_req"}, 32'(bus.dmem_req), 32'd0);
    chk({tag, "_rf_we"},    32'(rf_we),        32'd0);
    chk({tag, "_halted"},   32'(halted),       32'd0);
    chk({tag, "_pc"},       pc,                32'h100);
    chk({tag, "_ir"},       ir,                32'h13);
    chk({tag, "_instret"},  instret,           32'd0);
  endtask

  // Add an instruction and pin the model's cycle count against a literal.
  task automatic instr_cycles(input string name, input logic [31:0] instr, input int fw,
                              input int dw, input logic taken, input logic [31:0] tgt,
                              input logic noise, input int exp_cycles);
    int n;
    n = q.size();
    add_instr(instr, fw, dw, taken, tgt, noise);
    chk({name, "_cycles"}, 32'(q.size() - n), 32'(exp_cycles));
    run();
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0; bus.dmem_ready = 1'b0;
    branch_taken = 1'b0; target = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    instr_cycles("addi",     32'h0050_0093, 0, 0, 1'b0, 32'h0,   1'b0, 4);
    chk("addi_pc", pc, 32'h104);
    chk("addi_instret", instret, 32'd1);
    instr_cycles("addi_w3",  32'h00a0_0113, 3, 0, 1'b0, 32'h0,   1'b1, 7);
    chk("addi_w3_ir", ir, 32'h00a0_0113);
    instr_cycles("lui",      32'h1234_50b7, 0, 0, 1'b0, 32'h0,   1'b1, 4);
    instr_cycles("add",      32'h0020_81b3, 1, 0, 1'b1, 32'h0,   1'b0, 5);
    chk("add_pc", pc, 32'h110);
    instr_cycles("beq_t",    32'h0000_0463, 0, 0, 1'b1, 32'h200, 1'b1, 3);
    chk("beq_t_pc", pc, 32'h200);
    chk("beq_t_instret", instret, 32'd5);
    instr_cycles("beq_nt",   32'h0000_0463, 0, 0, 1'b0, 32'h200, 1'b0, 3);
    chk("beq_nt_pc", pc, 32'h204);
    instr_cycles("sw",       32'h0011_2023, 0, 2, 1'b0, 32'h0,   1'b1, 6);
    chk("sw_pc", pc, 32'h208);
    chk("sw_instret", instret, 32'd7);
    instr_cycles("jal",      32'h0080_00ef, 0, 0, 1'b0, 32'h300, 1'b1, 4);
    chk("jal_pc", pc, 32'h300);
    instr_cycles("beq_mis",  32'h0000_0463, 0, 0, 1'b1, 32'h302, 1'b0, 3);
    add_idle(5, 1'b1);
    run();
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_pc", pc, 32'h300);
    chk("mis_instret", instret, 32'd8);

    rst = 1'b1;
    #1;
    check_reset_vals("rst_halt");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    instr_cycles("addi2",    32'h0050_0093, 0, 0, 1'b0, 32'h0,   1'b0, 4);
    chk("addi2_pc", pc, 32'h104);
    bus.imem_ready = 1'b0;
    @(negedge clk);
    chk("midfetch_req", 32'(bus.imem_req), 32'd1);
    chk("midfetch_addr", bus.imem_addr, 32'h104);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_midfetch");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    instr_cycles("illegal",  32'h0000_2083, 0, 0, 1'b0, 32'h0,   1'b1, 2);
    add_idle(6, 1'b1);
    run();
    chk("ill_halted", 32'(halted), 32'd1);
    chk("ill_pc", pc, 32'h100);
    chk("ill_imem_req", 32'(bus.imem_req), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
